// File: rtl/sd_cmd_phy_pkg.sv
// Shared definitions for the SD CMD-line transceiver: frame sizes, CRC7 polynomial, FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
// Consumers import this package; nothing here holds state.
package sd_cmd_phy_pkg;

    localparam int CMD_BITS        = 48;
    localparam int RESP_SHORT_BITS = 48;
    localparam int RESP_LONG_BITS  = 136;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_WAIT  = 2'd1,
        TX_SHIFT = 2'd2,
        TX_END   = 2'd3
    } tx_state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one message bit per enabled cycle, MSB first.
// Result visible the cycle after the last enabled bit; clear has priority over enable.
// No backpressure: the caller decides when a bit is valid.
module sd_crc7
    import sd_cmd_phy_pkg::*;
(
    input  logic       CLK,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    always_ff @(posedge CLK) begin
        if (i_rst || i_clr) begin
            o_crc <= 7'h00;
        end else if (i_en) begin
            o_crc <= crc7_step(o_crc, i_bit);
        end
    end

endmodule

// File: rtl/sd_cmd_phy.sv
// Card-side SD CMD transceiver: decodes 48-bit host commands, serialises 48/136-bit responses.
// Command pulse 1 CLK after the end-bit rise pulse; pin updates 1 CLK after each SD-clock fall pulse.
// Responses accepted only while o_resp_ready; the requester must hold i_resp_valid until then.
module sd_cmd_phy
    import sd_cmd_phy_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NCR_CYCLES  = 2
) (
    input  logic         CLK,
    input  logic         i_rst,
    input  logic         i_sd_clk,
    input  logic         i_sd_cmd,
    output logic         o_sd_cmd,
    output logic         o_sd_cmd_oe,
    output logic         o_cmd_valid,
    output logic         o_cmd_err,
    output logic [5:0]   o_cmd_index,
    output logic [31:0]  o_cmd_arg,
    input  logic         i_resp_valid,
    output logic         o_resp_ready,
    input  logic         i_resp_long,
    input  logic         i_resp_no_crc,
    input  logic [127:0] i_resp_data
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cmd_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   cmd_s;
    logic                   sd_rise;
    logic                   sd_fall;

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            clk_sync <= '0;
            cmd_sync <= '1;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= (clk_sync << 1) | SYNC_STAGES'(i_sd_clk);
            cmd_sync <= (cmd_sync << 1) | SYNC_STAGES'(i_sd_cmd);
            clk_prev <= clk_s;
        end
    end

    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign cmd_s   = cmd_sync[SYNC_STAGES-1];
    assign sd_rise = clk_s & ~clk_prev;
    assign sd_fall = ~clk_s & clk_prev;

    // ---------------- receive ----------------
    rx_state_t             rx_state;
    rx_state_t             rx_state_n;
    tx_state_t             tx_state;
    tx_state_t             tx_state_n;
    logic [CMD_BITS-1:0]   rx_shift;
    logic [5:0]            rx_cnt;
    logic [6:0]            rx_crc;
    logic                  rx_crc_clr;
    logic                  rx_crc_en;
    logic                  rx_ok;

    // Start bit is zero, so clearing on it equals absorbing it into the CRC.
    assign rx_ok = !rx_shift[47] && rx_shift[46] && rx_shift[0] && (rx_crc == rx_shift[7:1]);

    always_comb begin
        rx_state_n  = rx_state;
        rx_crc_clr  = 1'b0;
        rx_crc_en   = 1'b0;
        o_cmd_valid = 1'b0;
        o_cmd_err   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (sd_rise && !cmd_s) begin
                    rx_state_n = RX_SHIFT;
                    rx_crc_clr = 1'b1;
                end
            end
            RX_SHIFT: begin
                if (sd_rise) begin
                    rx_crc_en = (rx_cnt < 6'd40);
                    if (rx_cnt == 6'(CMD_BITS - 1)) begin
                        rx_state_n = RX_CHECK;
                    end
                end
            end
            RX_CHECK: begin
                o_cmd_valid = rx_ok;
                o_cmd_err   = !rx_ok;
                rx_state_n  = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
        // The card must never decode its own response.
        if (tx_state != TX_IDLE) begin
            rx_state_n = RX_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            rx_shift    <= '0;
            rx_cnt      <= 6'd0;
            o_cmd_index <= 6'd0;
            o_cmd_arg   <= 32'd0;
        end else begin
            if (sd_rise) begin
                rx_shift <= {rx_shift[CMD_BITS-2:0], cmd_s};
            end
            if (rx_state == RX_IDLE) begin
                rx_cnt <= 6'd1;
            end else if (rx_state == RX_SHIFT && sd_rise) begin
                rx_cnt <= rx_cnt + 6'd1;
            end
            if (rx_state == RX_CHECK && rx_ok) begin
                o_cmd_index <= rx_shift[45:40];
                o_cmd_arg   <= rx_shift[39:8];
            end
        end
    end

    sd_crc7 u_rx_crc (
        .CLK   (CLK),
        .i_rst (i_rst),
        .i_clr (rx_crc_clr),
        .i_en  (rx_crc_en),
        .i_bit (cmd_s),
        .o_crc (rx_crc)
    );

    // ---------------- transmit ----------------
    logic [RESP_LONG_BITS-1:0] tx_shift;
    logic [RESP_LONG_BITS-1:0] tx_shift_n;
    logic [7:0]                tx_cnt;
    logic [7:0]                tx_last;
    logic [7:0]                tx_crc_pos;
    logic [6:0]                tx_wait;
    logic [6:0]                tx_crc;
    logic                      tx_long;
    logic                      tx_no_crc;
    logic                      tx_hold;
    logic                      tx_bit;
    logic                      tx_crc_en;
    logic                      do_shift;
    logic                      accept;

    assign o_resp_ready = (tx_state == TX_IDLE) && !i_rst;
    assign accept       = i_resp_valid && o_resp_ready;
    assign tx_last      = tx_long ? 8'(RESP_LONG_BITS - 1) : 8'(RESP_SHORT_BITS - 1);
    assign tx_crc_pos   = tx_long ? 8'd128 : 8'd40;

    always_comb begin
        tx_state_n = tx_state;
        do_shift   = 1'b0;
        tx_bit     = tx_shift[RESP_LONG_BITS-1];
        tx_shift_n = {tx_shift[RESP_LONG_BITS-2:0], 1'b0};
        case (tx_state)
            TX_IDLE: begin
                if (accept) begin
                    tx_state_n = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (sd_fall && tx_wait == 7'(NCR_CYCLES - 1)) begin
                    do_shift   = 1'b1;
                    tx_state_n = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (sd_fall) begin
                    do_shift = 1'b1;
                    if (tx_cnt == tx_last) begin
                        tx_state_n = TX_END;
                    end
                end
            end
            TX_END: begin
                if (sd_fall && tx_hold) begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // The frame is preloaded with the raw CRC field; splice in the computed one when it is due.
        if (tx_cnt == tx_crc_pos && !tx_no_crc) begin
            tx_bit                                        = tx_crc[6];
            tx_shift_n[RESP_LONG_BITS-1:RESP_LONG_BITS-6] = tx_crc[5:0];
        end
        tx_crc_en = do_shift && (tx_long ? (tx_cnt >= 8'd8 && tx_cnt < 8'd128) : (tx_cnt < 8'd40));
    end

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            o_sd_cmd    <= 1'b1;
            o_sd_cmd_oe <= 1'b0;
            tx_shift    <= '0;
            tx_cnt      <= 8'd0;
            tx_wait     <= 7'd0;
            tx_long     <= 1'b0;
            tx_no_crc   <= 1'b0;
            tx_hold     <= 1'b0;
        end else begin
            if (accept) begin
                tx_long   <= i_resp_long;
                tx_no_crc <= i_resp_no_crc;
                tx_cnt    <= 8'd0;
                tx_wait   <= 7'd0;
                tx_hold   <= 1'b0;
                tx_shift  <= i_resp_long ? {2'b00, 6'h3F, i_resp_data[127:1], 1'b1}
                                         : {2'b00, i_resp_data[37:0], 7'h7F, 1'b1, 88'd0};
            end
            if (tx_state == TX_WAIT && sd_fall) begin
                tx_wait <= tx_wait + 7'd1;
            end
            if (do_shift) begin
                o_sd_cmd    <= tx_bit;
                o_sd_cmd_oe <= 1'b1;
                tx_shift    <= tx_shift_n;
                tx_cnt      <= tx_cnt + 8'd1;
            end
            if (tx_state == TX_END && sd_fall) begin
                tx_hold <= 1'b1;
                if (tx_hold) begin
                    o_sd_cmd_oe <= 1'b0;
                    o_sd_cmd    <= 1'b1;
                end
            end
        end
    end

    sd_crc7 u_tx_crc (
        .CLK   (CLK),
        .i_rst (i_rst),
        .i_clr (accept),
        .i_en  (tx_crc_en),
        .i_bit (tx_shift[RESP_LONG_BITS-1]),
        .o_crc (tx_crc)
    );

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Bench for sd_cmd_phy: host-side command driver, response capture, and a polynomial-division CRC7 model.
// Random commands (good and corrupted) and random responses are compared with expectations built from the frame rules.
module tb_sd_cmd_phy;

    localparam int NCR  = 2;
    localparam int SYNC = 2;
    localparam int HALF = 6;
    localparam int LAT  = SYNC + 1;

    logic         CLK = 1'b0;
    logic         i_rst;
    logic         i_sd_clk;
    logic         i_sd_cmd;
    logic         o_sd_cmd;
    logic         o_sd_cmd_oe;
    logic         o_cmd_valid;
    logic         o_cmd_err;
    logic [5:0]   o_cmd_index;
    logic [31:0]  o_cmd_arg;
    logic         i_resp_valid;
    logic         o_resp_ready;
    logic         i_resp_long;
    logic         i_resp_no_crc;
    logic [127:0] i_resp_data;

    int n_err = 0;
    int n_chk = 0;
    int n_valid = 0;
    int n_cerr = 0;

    logic [5:0]  exp_index;
    logic [31:0] exp_arg;

    always #5 CLK = ~CLK;

    sd_cmd_phy #(.SYNC_STAGES(SYNC), .NCR_CYCLES(NCR)) dut (
        .CLK           (CLK),
        .i_rst         (i_rst),
        .i_sd_clk      (i_sd_clk),
        .i_sd_cmd      (i_sd_cmd),
        .o_sd_cmd      (o_sd_cmd),
        .o_sd_cmd_oe   (o_sd_cmd_oe),
        .o_cmd_valid   (o_cmd_valid),
        .o_cmd_err     (o_cmd_err),
        .o_cmd_index   (o_cmd_index),
        .o_cmd_arg     (o_cmd_arg),
        .i_resp_valid  (i_resp_valid),
        .o_resp_ready  (o_resp_ready),
        .i_resp_long   (i_resp_long),
        .i_resp_no_crc (i_resp_no_crc),
        .i_resp_data   (i_resp_data)
    );

    always @(negedge CLK) begin
        if (o_cmd_valid === 1'b1) n_valid++;
        if (o_cmd_err === 1'b1) n_cerr++;
    end

    task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1; msg occupies the low nbits bits.
    function automatic logic [6:0] crc7_ref(input logic [127:0] msg, input int nbits);
        logic [134:0] r;
        r = 135'(msg) << 7;
        for (int i = nbits + 6; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7_ref(128'(head), 40), 1'b1};
    endfunction

    function automatic logic frame_ok(input logic [47:0] f);
        return f[46] && f[0] && (crc7_ref(128'(f[47:8]), 40) == f[7:1]);
    endfunction

    function automatic logic [135:0] exp_resp(input logic long_r, input logic no_crc, input logic [127:0] d);
        logic [6:0] crc;
        if (long_r) begin
            crc = no_crc ? d[7:1] : crc7_ref(128'(d[127:8]), 120);
            return {2'b00, 6'h3F, d[127:8], crc, 1'b1};
        end
        crc = no_crc ? 7'h7F : crc7_ref(128'({2'b00, d[37:0]}), 40);
        return 136'({2'b00, d[37:0], crc, 1'b1});
    endfunction

    task automatic send_cmd(input string tag, input logic [47:0] frame);
        int   nv0;
        int   ne0;
        int   lat;
        logic good;
        good = frame_ok(frame);
        nv0  = n_valid;
        ne0  = n_cerr;
        lat  = 0;
        for (int i = 47; i >= 0; i--) begin
            i_sd_cmd = frame[i];
            repeat (HALF) @(negedge CLK);
            i_sd_clk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge CLK);
                if (i == 0 && lat == 0 && (o_cmd_valid || o_cmd_err)) lat = k;
            end
            i_sd_clk = 1'b0;
        end
        i_sd_cmd = 1'b1;
        repeat (HALF) @(negedge CLK);
        check_val({tag, "_valid"}, 136'(n_valid - nv0), 136'(good));
        check_val({tag, "_err"}, 136'(n_cerr - ne0), 136'(!good));
        check_val({tag, "_lat"}, 136'(lat), 136'(LAT));
        if (good) begin
            exp_index = frame[45:40];
            exp_arg   = frame[39:8];
        end
        check_val({tag, "_index"}, 136'(o_cmd_index), 136'(exp_index));
        check_val({tag, "_arg"}, 136'(o_cmd_arg), 136'(exp_arg));
    endtask

    task automatic run_resp(input string tag, input logic long_r, input logic no_crc,
                            input logic [127:0] data, input int abort_at, output logic [135:0] got);
        logic q[$];
        int   n;
        int   first;
        int   nv0;
        int   ne0;
        bit   done;
        n   = long_r ? 136 : 48;
        got = '0;
        @(negedge CLK);
        check_val({tag, "_ready"}, 136'(o_resp_ready), 136'(1));
        i_resp_long   = long_r;
        i_resp_no_crc = no_crc;
        i_resp_data   = data;
        i_resp_valid  = 1'b1;
        @(negedge CLK);
        i_resp_valid = 1'b0;
        check_val({tag, "_busy"}, 136'(o_resp_ready), 136'(0));
        nv0   = n_valid;
        ne0   = n_cerr;
        first = -1;
        done  = 1'b0;
        for (int f = 1; f <= 400 && !done; f++) begin
            i_sd_cmd = 1'($urandom);
            i_sd_clk = 1'b1;
            repeat (HALF) @(negedge CLK);
            i_sd_clk = 1'b0;
            repeat (HALF) @(negedge CLK);
            if (o_sd_cmd_oe) begin
                if (first < 0) first = f;
                q.push_back(o_sd_cmd);
            end else if (first >= 0) begin
                done = 1'b1;
            end
            if (abort_at > 0 && q.size() == abort_at) done = 1'b1;
        end
        i_sd_cmd = 1'b1;
        check_val({tag, "_rx_quiet"}, 136'((n_valid - nv0) + (n_cerr - ne0)), 136'(0));
        check_val({tag, "_first_fall"}, 136'(first), 136'(NCR));
        if (abort_at > 0) begin
            check_val({tag, "_abort_bits"}, 136'(q.size()), 136'(abort_at));
            return;
        end
        check_val({tag, "_oe_len"}, 136'(q.size()), 136'(n + 1));
        for (int i = 0; i < n && i < q.size(); i++) got = {got[134:0], q[i]};
        check_val({tag, "_bits"}, got, exp_resp(long_r, no_crc, data));
        check_val({tag, "_hold"}, 136'((q.size() > n) ? q[n] : 1'b0), 136'(1));
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

    initial begin
        logic [135:0] got;
        logic [47:0]  fr;
        logic [127:0] d;
        int           kind;

        i_rst         = 1'b1;
        i_sd_clk      = 1'b0;
        i_sd_cmd      = 1'b1;
        i_resp_valid  = 1'b0;
        i_resp_long   = 1'b0;
        i_resp_no_crc = 1'b0;
        i_resp_data   = '0;
        exp_index     = 6'd0;
        exp_arg       = 32'd0;
        repeat (4) @(negedge CLK);

        check_val("rst_cmd", 136'(o_sd_cmd), 136'(1));
        check_val("rst_oe", 136'(o_sd_cmd_oe), 136'(0));
        check_val("rst_valid", 136'(o_cmd_valid), 136'(0));
        check_val("rst_err", 136'(o_cmd_err), 136'(0));
        check_val("rst_index", 136'(o_cmd_index), 136'(0));
        check_val("rst_arg", 136'(o_cmd_arg), 136'(0));
        check_val("rst_ready", 136'(o_resp_ready), 136'(0));
        i_rst = 1'b0;
        @(negedge CLK);
        check_val("ready_after_rst", 136'(o_resp_ready), 136'(1));

        fr = mk_cmd(6'd0, 32'h0);
        check_val("cmd0_model_crc", 136'(fr[7:1]), 136'(7'h4A));
        send_cmd("cmd0", fr);

        fr = mk_cmd(6'd8, 32'h1AA);
        check_val("cmd8_model_crc", 136'(fr[7:1]), 136'(7'h43));
        send_cmd("cmd8", fr);
        fr[7:1] = 7'h42;
        send_cmd("cmd8_badcrc", fr);

        for (int t = 0; t < 6; t++) begin
            fr   = mk_cmd(6'($urandom), $urandom);
            kind = $urandom_range(0, 3);
            if (kind == 1) fr[1 + $urandom_range(0, 6)] ^= 1'b1;
            if (kind == 2) fr[46] = 1'b0;
            if (kind == 3) fr[0] = 1'b0;
            send_cmd($sformatf("rnd_cmd%0d_k%0d", t, kind), fr);
        end

        run_resp("r7", 1'b0, 1'b0, 128'({6'd8, 32'h000001AA}), 0, got);
        check_val("r7_bytes", got, 136'(48'h08_00_00_01_AA_13));

        run_resp("r3", 1'b0, 1'b1, 128'({6'h3F, 32'hC0FF8000}), 0, got);
        check_val("r3_bytes", got, 136'(48'h3F_C0_FF_80_00_FF));

        d = 128'h0353_4453_4430_3332_8012_3456_7801_7F01;
        run_resp("r2", 1'b1, 1'b0, d, 0, got);
        check_val("r2_first_byte", 136'(got[135:128]), 136'(8'h3F));
        check_val("r2_crc", 136'(got[7:1]), 136'(crc7_ref(128'(d[127:8]), 120)));

        for (int t = 0; t < 2; t++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_resp($sformatf("rnd_resp%0d", t), 1'($urandom), 1'($urandom), d, 0, got);
        end

        fr = mk_cmd(6'($urandom), $urandom);
        send_cmd("post_resp_cmd", fr);

        run_resp("abort", 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 20, got);
        i_rst = 1'b1;
        @(negedge CLK);
        check_val("abort_oe", 136'(o_sd_cmd_oe), 136'(0));
        check_val("abort_cmd", 136'(o_sd_cmd), 136'(1));
        check_val("abort_ready_in_rst", 136'(o_resp_ready), 136'(0));
        i_rst = 1'b0;
        @(negedge CLK);
        check_val("abort_ready_after", 136'(o_resp_ready), 136'(1));
        exp_index = 6'd0;
        exp_arg   = 32'd0;
        check_val("abort_index_cleared", 136'(o_cmd_index), 136'(0));
        send_cmd("cmd55", mk_cmd(6'd55, {16'($urandom), 16'h0000}));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
